clk_div_ctrl: RTL

Run/stop and reconfiguration sequencer for a 32-bit clk_div instance. Accepts new divisor values over a valid/ready handshake and stops, reprograms and restarts the divider without producing a truncated high pulse on its clk_out. Sits between the register/config logic and the divider. Observes the divider output as clk_fb.

---
 rtl/clk_div_pkg.sv | 15 +
 rtl/clk_div_ctrl_if.sv | 13 +
 rtl/clk_div.sv | 28 ++
 rtl/clk_div_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types for the clk_div run/stop/reconfiguration controller.
// Holds the controller state encoding and the default divisor width.
// No logic; imported by the controller and its interface users.
package clk_div_pkg;

  localparam int DIV_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Divisor configuration handshake between register logic and clk_div_ctrl.
// A divisor transfers on any clk_in edge where cfg_valid & cfg_ready.
// The controller drops cfg_ready while it drains or holds the divider.
interface clk_div_ctrl_if #(
  parameter int DIV_W = 32
);
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_div, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div.sv
// Programmable clock divider: clk_out period = 2*(div+1) clk cycles, 50% duty.
// clk_out is registered; first rising edge div+1 cycles after rst drops.
// No backpressure; rst holds clk_out low and clears the phase counter.
module clk_div #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  output logic             clk_out
);

  logic [DIV_W-1:0] r_cnt;

  // Count div+1 cycles per half period, then flip the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      clk_out <= 1'b0;
    end else if (r_cnt == div) begin
      r_cnt   <= '0;
      clk_out <= ~clk_out;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Stops, reprograms and restarts a clk_div without truncating a high pulse.
// Restart latency SETTLE_CYCLES+1 edges; stop waits for clk_fb low (<= div+2).
// cfg_ready low in DRAIN/HOLD; optional CLK_DIV_CTRL_TIMEOUT_EN bounds DRAIN.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int               DIV_W         = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DEFAULT_DIV   = '0,
  parameter int               SETTLE_CYCLES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run,
  clk_div_ctrl_if.slave    cfg,
  input  logic             clk_fb,
  output logic [DIV_W-1:0] div_out,
  output logic             div_rst,
  output logic             busy,
  output logic             locked
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);

  localparam int             SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  state_t           r_state;
  logic [DIV_W-1:0] r_pend_div;
  logic             r_stop_req;
  logic [SW-1:0]    r_settle_cnt;
  logic             w_accept;
  logic             w_tmo;

  assign w_accept = cfg.cfg_valid & cfg.cfg_ready;

`ifdef CLK_DIV_CTRL_TIMEOUT_EN
  logic [DIV_W:0] r_tmo_cnt;

  // Fires in the DRAIN cycle that completes div_out+3 cycles with clk_fb stuck high.
  assign w_tmo = (r_state == DRAIN) && clk_fb &&
                 ((r_tmo_cnt + (DIV_W+1)'(1)) == ({1'b0, div_out} + (DIV_W+1)'(3)));

  // Count cycles spent in DRAIN and latch a sticky error when the bound is hit.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_tmo_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (r_state == DRAIN) r_tmo_cnt <= r_tmo_cnt + (DIV_W+1)'(1);
      else                  r_tmo_cnt <= '0;
      if (w_tmo) timeout_err <= 1'b1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  // Divider reset: in DRAIN it follows ~clk_fb so the divider clears only while clk_out is low.
  always_comb begin
    div_rst = 1'b1;
    case (r_state)
      RUN:     div_rst = 1'b0;
      DRAIN:   div_rst = ~clk_fb | w_tmo;
      default: div_rst = 1'b1;
    endcase
  end

  // Sequencer FSM with registered status outputs updated on each transition.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state       <= IDLE;
      div_out       <= DEFAULT_DIV;
      r_pend_div    <= DEFAULT_DIV;
      r_stop_req    <= 1'b0;
      r_settle_cnt  <= '0;
      locked        <= 1'b0;
      busy          <= 1'b0;
      cfg.cfg_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          // Divider is held in reset here, so a new divisor can go straight out.
          if (w_accept) begin
            div_out    <= cfg.cfg_div;
            r_pend_div <= cfg.cfg_div;
          end
          if (run) begin
            r_state       <= HOLD;
            r_stop_req    <= 1'b0;
            r_settle_cnt  <= '0;
            busy          <= 1'b1;
            cfg.cfg_ready <= 1'b0;
          end
        end
        HOLD: begin
          if (r_settle_cnt == SETTLE_LAST) begin
            busy          <= 1'b0;
            cfg.cfg_ready <= 1'b1;
            if (r_stop_req || !run) begin
              r_state <= IDLE;
            end else begin
              r_state <= RUN;
              locked  <= 1'b1;
            end
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        RUN: begin
          if (w_accept || !run) begin
            r_state       <= DRAIN;
            r_stop_req    <= ~run;
            locked        <= 1'b0;
            busy          <= 1'b1;
            cfg.cfg_ready <= 1'b0;
            if (w_accept) r_pend_div <= cfg.cfg_div;
          end
        end
        DRAIN: begin
          // div_rst is already high this cycle, so the divider clears on this same edge.
          if (!clk_fb || w_tmo) begin
            r_state      <= HOLD;
            div_out      <= r_pend_div;
            r_settle_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule
